// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the UART receive-side command decoder: FSM states,
// command byte codes and the fixed register-file slots used for ALU operands.
package sys_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_ADDR  = 4'd1,
        WR_DATA  = 4'd2,
        RD_ADDR  = 4'd3,
        OPA      = 4'd4,
        OPB      = 4'd5,
        FUN      = 4'd6,
        WAIT_RD  = 4'd7,
        WAIT_ALU = 4'd8
    } state_e;

    localparam logic [7:0] CMD_RF_WR     = 8'hAA;
    localparam logic [7:0] CMD_RF_RD     = 8'hBB;
    localparam logic [7:0] CMD_ALU_W_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NO_OP = 8'hDD;

    localparam int OPA_ADDR = 0;
    localparam int OPB_ADDR = 1;

    // States that are mid-frame and waiting on another byte from the UART.
    function automatic logic is_timed_state(input state_e s);
        case (s)
            WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN: is_timed_state = 1'b1;
            default:                                  is_timed_state = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sys_ctrl_rx_timeout.sv
// Mid-frame inactivity counter: counts enabled cycles without a received byte
// and flags expiry when TIMEOUT_CYCLES idle cycles have elapsed.
module sys_ctrl_rx_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_expire
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;

    // Expiry is flagged on the edge that would complete the last idle cycle.
    assign o_expire = i_en && !i_clr && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Idle-cycle counter, cleared by any byte, by leaving a timed state or on expiry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en || o_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sys_ctrl_rx.sv
// Command decoder turning UART Rx byte frames into RF writes/reads and ALU ops.
// Optional mid-frame abort timer enabled by defining SYS_CTRL_RX_TIMEOUT_EN.
module sys_ctrl_rx
    import sys_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int FUN_WIDTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  RdData_Valid,
    input  logic                  OUT_Valid,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic                  ALU_EN,
    output logic [FUN_WIDTH-1:0]  ALU_FUN,
    output logic                  CLK_EN
);
    state_e                r_state;
    state_e                w_state_dec;
    state_e                w_state_nxt;
    logic                  w_tmo_expire;
    logic [ADDR_WIDTH-1:0] w_addr_nxt;
    logic [DATA_WIDTH-1:0] w_wrdata_nxt;
    logic [FUN_WIDTH-1:0]  w_fun_nxt;
    logic                  w_wren_nxt;
    logic                  w_rden_nxt;
    logic                  w_aluen_nxt;
    logic                  w_clken_nxt;

`ifdef SYS_CTRL_RX_TIMEOUT_EN
    sys_ctrl_rx_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (CLK),
        .i_rst_n  (RST),
        .i_en     (is_timed_state(r_state)),
        .i_clr    (RX_D_VLD),
        .o_expire (w_tmo_expire)
    );
`else
    assign w_tmo_expire = 1'b0;
`endif

    // State register and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= IDLE;
            Address <= '0;
            WrData  <= '0;
            ALU_FUN <= '0;
            WrEn    <= 1'b0;
            RdEn    <= 1'b0;
            ALU_EN  <= 1'b0;
            CLK_EN  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            Address <= w_addr_nxt;
            WrData  <= w_wrdata_nxt;
            ALU_FUN <= w_fun_nxt;
            WrEn    <= w_wren_nxt;
            RdEn    <= w_rden_nxt;
            ALU_EN  <= w_aluen_nxt;
            CLK_EN  <= w_clken_nxt;
        end
    end

    // Next-state decode; bytes arriving in the wait states are simply dropped.
    always_comb begin
        w_state_dec = r_state;
        case (r_state)
            IDLE: begin
                if (RX_D_VLD) begin
                    case (RX_P_DATA[7:0])
                        CMD_RF_WR:     w_state_dec = WR_ADDR;
                        CMD_RF_RD:     w_state_dec = RD_ADDR;
                        CMD_ALU_W_OP:  w_state_dec = OPA;
                        CMD_ALU_NO_OP: w_state_dec = FUN;
                        default:       w_state_dec = IDLE;
                    endcase
                end else begin
                    w_state_dec = IDLE;
                end
            end
            WR_ADDR:  w_state_dec = RX_D_VLD ? WR_DATA : WR_ADDR;
            WR_DATA:  w_state_dec = RX_D_VLD ? IDLE    : WR_DATA;
            RD_ADDR:  w_state_dec = RX_D_VLD ? WAIT_RD : RD_ADDR;
            OPA:      w_state_dec = RX_D_VLD ? OPB     : OPA;
            OPB:      w_state_dec = RX_D_VLD ? FUN     : OPB;
            FUN:      w_state_dec = RX_D_VLD ? WAIT_ALU : FUN;
            WAIT_RD:  w_state_dec = RdData_Valid ? IDLE : WAIT_RD;
            WAIT_ALU: w_state_dec = OUT_Valid ? IDLE : WAIT_ALU;
            default:  w_state_dec = IDLE;
        endcase
        w_state_nxt = w_tmo_expire ? IDLE : w_state_dec;
    end

    // Output decode: values loaded into the output registers on the next edge.
    always_comb begin
        w_addr_nxt   = Address;
        w_wrdata_nxt = WrData;
        w_fun_nxt    = ALU_FUN;
        w_wren_nxt   = 1'b0;
        w_rden_nxt   = 1'b0;
        w_aluen_nxt  = 1'b0;
        w_clken_nxt  = CLK_EN;
        case (r_state)
            WR_ADDR: begin
                if (RX_D_VLD) begin
                    w_addr_nxt = RX_P_DATA[ADDR_WIDTH-1:0];
                end else begin
                    w_addr_nxt = Address;
                end
            end
            WR_DATA: begin
                if (RX_D_VLD) begin
                    w_wrdata_nxt = RX_P_DATA;
                    w_wren_nxt   = 1'b1;
                end else begin
                    w_wren_nxt   = 1'b0;
                end
            end
            RD_ADDR: begin
                if (RX_D_VLD) begin
                    w_addr_nxt = RX_P_DATA[ADDR_WIDTH-1:0];
                    w_rden_nxt = 1'b1;
                end else begin
                    w_rden_nxt = 1'b0;
                end
            end
            OPA, OPB: begin
                if (RX_D_VLD) begin
                    w_addr_nxt   = (r_state == OPA) ? ADDR_WIDTH'(OPA_ADDR)
                                                    : ADDR_WIDTH'(OPB_ADDR);
                    w_wrdata_nxt = RX_P_DATA;
                    w_wren_nxt   = 1'b1;
                end else begin
                    w_wren_nxt   = 1'b0;
                end
            end
            FUN: begin
                if (RX_D_VLD) begin
                    w_fun_nxt   = RX_P_DATA[FUN_WIDTH-1:0];
                    w_aluen_nxt = 1'b1;
                    w_clken_nxt = 1'b1;
                end else begin
                    w_aluen_nxt = 1'b0;
                end
            end
            WAIT_ALU: begin
                if (OUT_Valid) begin
                    w_clken_nxt = 1'b0;
                end else begin
                    w_clken_nxt = 1'b1;
                end
            end
            default: begin
                w_wren_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/sys_ctrl_rx.md
Name: sys_ctrl_rx

Overview:
Command decoder for frames arriving from the UART receiver. It parses byte streams into register-file writes and reads, and ALU operations. It sits between the UART Rx parallel output and the register file/ALU, which makes it the front-end counterpart of the transmit-side controller that returns results to the UART Tx. One command is in flight at a time; a new frame is accepted only after the previous response is produced.

Parameters:
DATA_WIDTH, 8, byte width of UART payload, RF data and ALU operands
ADDR_WIDTH, 4, register-file address width (taken from the low bits of the address byte)
FUN_WIDTH, 4, ALU function-code width (taken from the low bits of the function byte)
TIMEOUT_CYCLES, 255, idle cycles mid-frame before abort (used only with the optional feature)

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous active-low reset
RX_P_DATA  in  DATA_WIDTH  received byte from UART Rx
RX_D_VLD  in  1  one-cycle strobe; RX_P_DATA valid
RdData_Valid  in  1  RF read data valid (response to RdEn)
OUT_Valid  in  1  ALU result valid
Address  out  ADDR_WIDTH  RF address
WrEn  out  1  RF write strobe, 1 cycle
RdEn  out  1  RF read strobe, 1 cycle
WrData  out  DATA_WIDTH  RF write data
ALU_EN  out  1  ALU start strobe, 1 cycle
ALU_FUN  out  FUN_WIDTH  ALU function code
CLK_EN  out  1  ALU clock-gate enable

Behaviour:
- Reset (RST low, async): state=IDLE. All outputs 0. Timeout counter 0.
- All outputs are registered. Strobes (WrEn, RdEn, ALU_EN) assert for exactly 1 cycle, on the cycle after the RX_D_VLD that completes the step. Address, WrData and ALU_FUN hold their value until next overwritten.
- Command bytes: RF_WR=0xAA, RF_RD=0xBB, ALU_W_OP=0xCC, ALU_NO_OP=0xDD. Other bytes in IDLE are dropped; state stays IDLE.
- States and transitions (each advance happens only on RX_D_VLD):
  - IDLE: on 0xAA go to WR_ADDR; on 0xBB go to RD_ADDR; on 0xCC go to OPA; on 0xDD go to FUN.
  - WR_ADDR: latch Address=byte[ADDR_WIDTH-1:0], go to WR_DATA.
  - WR_DATA: WrData=byte, pulse WrEn, go to IDLE. No response is expected.
  - RD_ADDR: Address=byte, pulse RdEn, go to WAIT_RD.
  - OPA: Address=0, WrData=byte, pulse WrEn, go to OPB.
  - OPB: Address=1, WrData=byte, pulse WrEn, go to FUN.
  - FUN: ALU_FUN=byte[FUN_WIDTH-1:0], pulse ALU_EN, set CLK_EN=1, go to WAIT_ALU.
  - WAIT_RD: on RdData_Valid go to IDLE.
  - WAIT_ALU: CLK_EN stays 1. On OUT_Valid, CLK_EN=0 and go to IDLE.
- RX_D_VLD during WAIT_RD or WAIT_ALU: the byte is dropped and is not queued.
- Response valid in the same cycle the wait state is entered: it is honoured, and the state goes to IDLE on the next edge.
- Address byte upper bits beyond ADDR_WIDTH are ignored. Function byte upper bits beyond FUN_WIDTH are ignored.
- Reset asserted mid-frame: immediate return to IDLE with outputs 0. The partial frame is discarded.
- Back-to-back frames: a command byte arriving in the cycle after a WR_DATA completion is decoded normally.

Optional Feature:
SYS_CTRL_RX_TIMEOUT_EN
- Defined:
  - A counter runs in WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB and FUN. It clears on every RX_D_VLD.
  - When it reaches TIMEOUT_CYCLES with no byte, the state returns to IDLE. No strobe fires. Already-issued operand writes are not undone.
  - Wait states are not timed.
- Not defined: no counter logic is present, and partial frames wait indefinitely.

Decomposition:
- Package sys_ctrl_pkg holds:
  - state enum/localparams (IDLE, WR_ADDR, WR_DATA, RD_ADDR, OPA, OPB, FUN, WAIT_RD, WAIT_ALU);
  - command codes 0xAA/0xBB/0xCC/0xDD;
  - operand register addresses OPA_ADDR=0 and OPB_ADDR=1.
- One sub-module is natural: sys_ctrl_rx_timeout, the counter with clear/enable/expire. It is instantiated only under the macro.

Test Plan:
- RF write: bytes AA,05,3C -> WrEn pulse 1 cycle after 3C, with Address=5 and WrData=0x3C; state back to IDLE.
- RF read: bytes BB,0A -> RdEn pulse with Address=0xA. Byte 0x77 sent during the wait is ignored. RdData_Valid returns to IDLE; then AA,01,FF performs a normal write.
- ALU with operands: CC,12,34,02 -> WrEn at Address 0 with data 0x12, then WrEn at Address 1 with data 0x34, then ALU_EN with ALU_FUN=2. CLK_EN stays high until OUT_Valid and drops in the following cycle.
- ALU without operands: DD,F8 -> no WrEn; ALU_EN with ALU_FUN=8 (upper bits dropped); CLK_EN behaves as in the previous scenario.
- Garbage and reset: byte 0x55 in IDLE -> no strobes. AA,03 then RST low -> all outputs 0 and IDLE; a subsequent 0x99 causes no write.
- Timeout (macro defined, TIMEOUT_CYCLES=16): CC,11 then 16 idle cycles -> IDLE. A following AA,02,44 writes Address 2 with data 0x44.
